// File: rtl/key_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// key_pulse_conditioner
//
// Purpose
//   Front end for the tug-of-war playfield. Turns the two raw, active-low,
//   asynchronous player keys into clean one-cycle press pulses L and R.
//   Each key path is: 2-flop synchronizer -> debouncer -> press-edge detector.
//   A final arbiter cancels presses that land in the same cycle, so L and R
//   are never high together.
//
// Parameters
//   DEBOUNCE_CYCLES  synced level must persist this many cycles to be accepted (>=1)
//   REPEAT_CYCLES    auto-repeat period in cycles, used only with AUTOREPEAT_EN (>=1)
//
// Configuration macro
//   AUTOREPEAT_EN    when defined, a held key produces an extra event every
//                    REPEAT_CYCLES cycles after its press event. When undefined,
//                    no repeat counter is built and each press yields one pulse.
//
// Ports
//   clock    in   system clock, all state updates on its rising edge
//   reset    in   asynchronous, active-high; clears all state immediately
//   key_l_n  in   raw left key (KEY[3]), asynchronous, 0 = pressed
//   key_r_n  in   raw right key (KEY[0]), asynchronous, 0 = pressed
//   L        out  one-cycle pulse, left press accepted
//   R        out  one-cycle pulse, right press accepted
// -----------------------------------------------------------------------------
module key_pulse_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic key_l_n,
   input  logic key_r_n,
   output logic L,
   output logic R
);

   // Key path indices used for every per-key vector below.
   localparam int KEY_L = 0;
   localparam int KEY_R = 1;
   localparam int N_KEYS = 2;

   // One counter width serves both debounce and repeat counters.
   localparam int MAX_CNT = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                              : REPEAT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [N_KEYS-1:0] sync1_q,  sync1_d;
   logic [N_KEYS-1:0] sync2_q,  sync2_d;
   logic [N_KEYS-1:0] stable_q, stable_d;
   logic [CNT_W-1:0]  cnt_q [N_KEYS];
   logic [CNT_W-1:0]  cnt_d [N_KEYS];
   logic              l_q, l_d;
   logic              r_q, r_d;

   logic [N_KEYS-1:0] press_evt;   // stable 1->0 at this edge
   logic [N_KEYS-1:0] rpt_evt;     // auto-repeat fire at this edge
   logic [N_KEYS-1:0] evt;         // any event presented to the arbiter

   // --------------------------------------------------------------------------
   // Synchronizer and debouncer, next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      sync1_d   = {key_r_n, key_l_n};
      sync2_d   = sync1_q;
      stable_d  = stable_q;
      press_evt = '0;
      for (int k = 0; k < N_KEYS; k++) begin
         cnt_d[k] = '0;
         if (sync2_q[k] != stable_q[k]) begin
            if (cnt_q[k] == DB_LAST) begin
               // Mismatch has persisted DEBOUNCE_CYCLES synced cycles: accept it.
               // Only the falling (press) direction is an event.
               stable_d[k]  = sync2_q[k];
               press_evt[k] = ~sync2_q[k];
            end else begin
               cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
         end
      end
   end

   // --------------------------------------------------------------------------
   // Optional auto-repeat
   // --------------------------------------------------------------------------
`ifdef AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] rpt_cnt_q [N_KEYS];
   logic [CNT_W-1:0] rpt_cnt_d [N_KEYS];

   // The counter is held at zero while the key is released, which also clears
   // it on the press edge itself; it then counts every cycle the key stays down
   // and fires each time it wraps, giving a period of REPEAT_CYCLES.
   always_comb begin
      rpt_evt = '0;
      for (int k = 0; k < N_KEYS; k++) begin
         rpt_cnt_d[k] = '0;
         if (!stable_q[k]) begin
            if (rpt_cnt_q[k] == RPT_LAST) begin
               rpt_evt[k] = 1'b1;
            end else begin
               rpt_cnt_d[k] = rpt_cnt_q[k] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < N_KEYS; k++) begin
            rpt_cnt_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < N_KEYS; k++) begin
            rpt_cnt_q[k] <= rpt_cnt_d[k];
         end
      end
   end
`else
   always_comb begin
      rpt_evt = '0;
   end
`endif

   // --------------------------------------------------------------------------
   // Cancel arbiter: events from both keys in the same cycle annul each other.
   // --------------------------------------------------------------------------
   always_comb begin
      evt = press_evt | rpt_evt;
      l_d = evt[KEY_L] & ~evt[KEY_R];
      r_d = evt[KEY_R] & ~evt[KEY_L];
   end

   // --------------------------------------------------------------------------
   // State register
   // --------------------------------------------------------------------------
   // Synchronizer and stable level reset to "released" so that a key held
   // across reset release is seen as a fresh press.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments only, so every
         // flop samples pre-edge values regardless of statement order.
         sync1_q  <= '1;
         sync2_q  <= '1;
         stable_q <= '1;
         // NOTE: the counter arrays are few flops and must start known, so
         // they are reset explicitly element by element.
         for (int k = 0; k < N_KEYS; k++) begin
            cnt_q[k] <= '0;
         end
         l_q <= 1'b0;
         r_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         for (int k = 0; k < N_KEYS; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
         l_q <= l_d;
         r_q <= r_d;
      end
   end

   assign L = l_q;
   assign R = r_q;

endmodule
